// File: rtl/seq_alu_hs_if.sv
// seq_alu_hs_if: operand/result valid-ready bus for the multi-cycle ALU
interface seq_alu_hs_if #(parameter int WIDTH = 8);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic                 flag;
  modport master (output in_valid, op, a, b, out_ready, input in_ready, out_valid, result, flag);
  modport slave  (input in_valid, op, a, b, out_ready, output in_ready, out_valid, result, flag);
endinterface

// File: rtl/seq_alu_hs.sv
// seq_alu_hs: multi-cycle add/sub/shift-add mul/restoring div with valid-ready handshake
module seq_alu_hs #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  seq_alu_hs_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           r_state, w_state_n;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_q, r_rem;
  logic [W2-1:0]    r_acc, r_sh, r_result;
  logic             r_flag;
  logic [CW-1:0]    r_cnt;
  logic             w_done, w_flag, w_div0;
  logic [WIDTH:0]   w_sum, w_diff, w_shift, w_trial;
  logic [W2-1:0]    w_mul, w_res;
  logic [WIDTH-1:0] w_rem_n, w_q_n;
  assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff  = {1'b0, r_a} - {1'b0, r_b};
  assign w_mul   = r_acc + (r_q[0] ? r_sh : '0);
  // restoring step: a borrow out of the trial subtract means keep the shifted remainder
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_b};
  assign w_rem_n = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_q_n   = {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_div0  = (r_op == 2'b11) && (r_b == '0);
  always_comb begin
    w_done    = (r_state == CALC) && (!r_op[1] || w_div0 || r_cnt == CW'(WIDTH - 1));
    w_state_n = r_state == IDLE ? (bus.in_valid ? CALC : IDLE) :
                r_state == CALC ? (w_done ? DONE : CALC) :
                                  (bus.out_ready ? IDLE : DONE);
    w_res     = r_op == 2'b00 ? W2'(w_sum) :
                r_op == 2'b01 ? W2'(w_diff[WIDTH-1:0]) :
                r_op == 2'b10 ? w_mul :
                w_div0        ? {r_a, {WIDTH{1'b1}}} : {w_rem_n, w_q_n};
    w_flag    = r_op == 2'b00 ? w_sum[WIDTH] :
                r_op == 2'b01 ? w_diff[WIDTH] :
                r_op == 2'b10 ? |w_mul[W2-1:WIDTH] : w_div0;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_acc    <= '0;
      r_sh     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_flag   <= 1'b0;
    end else if (r_state == IDLE && bus.in_valid) begin
      r_op  <= bus.op;
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_q   <= bus.op == 2'b10 ? bus.b : bus.a;
      r_rem <= '0;
      r_acc <= '0;
      r_sh  <= W2'(bus.a);
      r_cnt <= '0;
    end else if (r_state == CALC) begin
      if (w_done) begin
        r_result <= w_res;
        r_flag   <= w_flag;
      end else if (r_op == 2'b10) begin
        r_acc <= w_mul;
        r_sh  <= r_sh << 1;
        r_q   <= r_q >> 1;
      end else begin
        r_rem <= w_rem_n;
        r_q   <= w_q_n;
      end
      r_cnt <= r_cnt == CW'(WIDTH) ? r_cnt : r_cnt + CW'(1);
    end
  end
  assign bus.in_ready  = (r_state == IDLE) & ~rst;
  assign bus.out_valid = r_state == DONE;
  assign bus.result    = r_result;
  assign bus.flag      = r_flag;
endmodule

// File: tb/tb_seq_alu_hs.sv
// tb_seq_alu_hs: randomized and directed checks of seq_alu_hs against an arithmetic model
module tb_seq_alu_hs;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  seq_alu_hs_if #(.WIDTH(W)) bus();
  seq_alu_hs #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [16:0] model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    int unsigned xa, yb, r;
    logic f;
    xa = x;
    yb = y;
    case (o)
      2'd0: begin r = xa + yb; f = r > 255; end
      2'd1: begin r = (xa - yb) & 32'hFF; f = xa < yb; end
      2'd2: begin r = xa * yb; f = r > 255; end
      default: begin
        if (yb == 0) begin r = xa * 256 + 255; f = 1'b1; end
        else begin r = (xa % yb) * 256 + xa / yb; f = 1'b0; end
      end
    endcase
    return {f, r[15:0]};
  endfunction
  function automatic int exp_lat(input logic [1:0] o, input logic [7:0] y);
    return (o < 2 || (o == 3 && y == 0)) ? 1 : W;
  endfunction
  task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        input int stall, input logic sv, input logic [1:0] so,
                        input logic [7:0] sx, input logic [7:0] sy);
    logic [16:0] e;
    int k;
    int lat;
    e = model(o, x, y);
    k = 0;
    while (!bus.in_ready && k < 50) begin @(negedge clk); k++; end
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op = 2'($urandom_range(0, 3));
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin @(negedge clk); lat++; end
    chk("latency", 32'(lat), 32'(exp_lat(o, y)));
    chk("result", 32'(bus.result), 32'(e[15:0]));
    chk("flag", 32'(bus.flag), 32'(e[16]));
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = sv;
      bus.op = so;
      bus.a = sx;
      bus.b = sy;
      @(negedge clk);
      chk("hold_result", 32'(bus.result), 32'(e[15:0]));
      chk("hold_flag", 32'(bus.flag), 32'(e[16]));
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("release_valid", 32'(bus.out_valid), 32'd0);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [1:0] o;
    logic [7:0] x, y;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_flag", 32'(bus.flag), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op(2'd0, 8'd200, 8'd100, 0, 1'b0, 2'd0, 8'd0, 8'd0);
    run_op(2'd1, 8'd5, 8'd7, 0, 1'b0, 2'd0, 8'd0, 8'd0);
    run_op(2'd1, 8'd7, 8'd5, 0, 1'b0, 2'd0, 8'd0, 8'd0);
    run_op(2'd2, 8'd255, 8'd255, 0, 1'b0, 2'd0, 8'd0, 8'd0);
    run_op(2'd2, 8'd0, 8'd9, 0, 1'b0, 2'd0, 8'd0, 8'd0);
    run_op(2'd3, 8'd200, 8'd7, 0, 1'b0, 2'd0, 8'd0, 8'd0);
    run_op(2'd3, 8'd9, 8'd0, 0, 1'b0, 2'd0, 8'd0, 8'd0);
    run_op(2'd3, 8'd3, 8'd9, 0, 1'b0, 2'd0, 8'd0, 8'd0);
    run_op(2'd3, 8'd123, 8'd1, 0, 1'b0, 2'd0, 8'd0, 8'd0);
    run_op(2'd0, 8'd17, 8'd29, 5, 1'b1, 2'd1, 8'd7, 8'd5);
    run_op(2'd1, 8'd7, 8'd5, 0, 1'b0, 2'd0, 8'd0, 8'd0);
    bus.in_valid = 1'b1;
    bus.op = 2'd2;
    bus.a = 8'd255;
    bus.b = 8'd255;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_result", 32'(bus.result), 32'd0);
    chk("mid_rst_flag", 32'(bus.flag), 32'd0);
    chk("mid_rst_in_ready_after", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_valid_after_rst", 32'(bus.out_valid), 32'd0);
    end
    run_op(2'd0, 8'd1, 8'd1, 0, 1'b0, 2'd0, 8'd0, 8'd0);
    for (int n = 0; n < 60; n++) begin
      o = 2'($urandom_range(0, 3));
      x = 8'($urandom);
      y = 8'($urandom);
      case ($urandom_range(0, 7))
        0: y = 8'd0;
        1: x = 8'd0;
        2: y = 8'd1;
        3: x = 8'($urandom_range(0, 15));
        4: begin x = 8'd255; y = 8'd255; end
        default: ;
      endcase
      run_op(o, x, y, int'($urandom_range(0, 3)), 1'($urandom), 2'($urandom_range(0, 3)),
             8'($urandom), 8'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
